// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer.
// Holds the sequencer state encoding, the op codes carried on the 2-bit op
// input, and the single-cycle ALU used for add/sub/pass updates.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [2:0] MUL_LAST = 3'd7;

    // Returns {flag, value}: flag is carry-out for add, borrow for sub
    // (bit 8 of the 9-bit difference is set exactly when a < b), 0 for pass.
    function automatic logic [8:0] calc_alu(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [1:0] op_sel);
        logic [8:0] r;
        case (op_sel)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_PASS: r = {1'b0, b};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tgl_edge.sv
// Toggle-to-event converter.
// Ports: clk, reset_n (async active-low), tgl_i (toggle-encoded command
// level), evt_o (high for the cycle in which tgl_i differs from the level
// registered at the previous edge). The history register clears to 0 on
// reset, so the first level change after reset is the first event.
module tgl_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl_i,
    output logic evt_o
);

    logic prev_q;
    logic prev_d;

    // Next history value is simply the current toggle level.
    always_comb begin
        prev_d = tgl_i;
    end

    // Toggle history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign evt_o = tgl_i ^ prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// Toggle-commanded 8-bit accumulator sequencer.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   store_tgl/update_tgl/        toggle-encoded commands (each level change
//   show_tgl/clear_tgl           is one event)
//   operand[7:0], op[1:0]        sampled when a command is dispatched
//   result[7:0]                  acc when disp_total=1, else opnd_reg
//   disp_total                   display-source flag
//   ovf                          overflow of the last update (sticky)
//   busy                         high whenever the sequencer is not IDLE
//   done                         one-cycle pulse after store/update completes
// Store/update/show events are queued in one pending flag each and served
// from IDLE in priority store > update > show. Clear acts immediately.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       store_tgl,
    input  logic       update_tgl,
    input  logic       show_tgl,
    input  logic       clear_tgl,
    input  logic [7:0] operand,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       disp_total,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    logic evt_store;
    logic evt_update;
    logic evt_show;
    logic evt_clear;

    state_t      state_q,       state_d;
    logic [7:0]  acc_q,         acc_d;
    logic [7:0]  opnd_q,        opnd_d;
    logic        ovf_q,         ovf_d;
    logic        disp_q,        disp_d;
    logic        pend_store_q,  pend_store_d;
    logic        pend_update_q, pend_update_d;
    logic        pend_show_q,   pend_show_d;
    logic [7:0]  lat_opnd_q,    lat_opnd_d;
    logic [1:0]  lat_op_q,      lat_op_d;
    logic [15:0] mcand_q,       mcand_d;
    logic [7:0]  mplier_q,      mplier_d;
    logic [15:0] prod_q,        prod_d;
    logic [2:0]  cnt_q,         cnt_d;
    logic [7:0]  result_q,      result_d;
    logic        busy_q,        busy_d;
    logic        done_q,        done_d;

    logic [15:0] mul_sum;
    logic [8:0]  alu_res;

    tgl_edge u_edge_store  (.clk(clk), .reset_n(reset_n), .tgl_i(store_tgl),  .evt_o(evt_store));
    tgl_edge u_edge_update (.clk(clk), .reset_n(reset_n), .tgl_i(update_tgl), .evt_o(evt_update));
    tgl_edge u_edge_show   (.clk(clk), .reset_n(reset_n), .tgl_i(show_tgl),   .evt_o(evt_show));
    tgl_edge u_edge_clear  (.clk(clk), .reset_n(reset_n), .tgl_i(clear_tgl),  .evt_o(evt_clear));

    // Next-state, datapath and output decode for the sequencer.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        ovf_d         = ovf_q;
        disp_d        = disp_q;
        pend_store_d  = pend_store_q  | evt_store;
        pend_update_d = pend_update_q | evt_update;
        pend_show_d   = pend_show_q   | evt_show;
        lat_opnd_d    = lat_opnd_q;
        lat_op_d      = lat_op_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        prod_d        = prod_q;
        cnt_d         = cnt_q;

        // One shift-add step: add the shifted multiplicand when the current
        // multiplier LSB is set.
        mul_sum = prod_q + (mplier_q[0] ? mcand_q : 16'd0);
        alu_res = calc_alu(acc_q, lat_opnd_q, lat_op_q);

        if (evt_clear) begin
            // Clear wins over everything, including events seen this edge.
            state_d       = ST_IDLE;
            acc_d         = 8'd0;
            opnd_d        = 8'd0;
            ovf_d         = 1'b0;
            disp_d        = 1'b0;
            pend_store_d  = 1'b0;
            pend_update_d = 1'b0;
            pend_show_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A fresh event of the served type re-arms its flag.
                    if (pend_store_q) begin
                        pend_store_d = evt_store;
                        lat_opnd_d   = operand;
                        lat_op_d     = op;
                        state_d      = ST_LOAD;
                    end else if (pend_update_q) begin
                        pend_update_d = evt_update;
                        lat_opnd_d    = operand;
                        lat_op_d      = op;
                        mcand_d       = {8'd0, acc_q};
                        mplier_d      = operand;
                        prod_d        = 16'd0;
                        cnt_d         = 3'd0;
                        state_d       = (op == OP_MUL) ? ST_MUL : ST_EXEC;
                    end else if (pend_show_q) begin
                        pend_show_d = evt_show;
                        disp_d      = ~disp_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    acc_d   = lat_opnd_q;
                    opnd_d  = lat_opnd_q;
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end
                ST_EXEC: begin
                    acc_d   = alu_res[7:0];
                    ovf_d   = alu_res[8];
                    opnd_d  = lat_opnd_q;
                    state_d = ST_DONE;
                end
                ST_MUL: begin
                    prod_d   = mul_sum;
                    mcand_d  = {mcand_q[14:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[7:1]};
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == MUL_LAST) begin
                        acc_d   = mul_sum[7:0];
                        ovf_d   = |mul_sum[15:8];
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from next-state values so they register
        // alongside the state they describe.
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        result_d = disp_d ? acc_d : opnd_d;
    end

    // Sequencer state, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= 8'd0;
            opnd_q        <= 8'd0;
            ovf_q         <= 1'b0;
            disp_q        <= 1'b0;
            pend_store_q  <= 1'b0;
            pend_update_q <= 1'b0;
            pend_show_q   <= 1'b0;
            lat_opnd_q    <= 8'd0;
            lat_op_q      <= 2'd0;
            mcand_q       <= 16'd0;
            mplier_q      <= 8'd0;
            prod_q        <= 16'd0;
            cnt_q         <= 3'd0;
            result_q      <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            ovf_q         <= ovf_d;
            disp_q        <= disp_d;
            pend_store_q  <= pend_store_d;
            pend_update_q <= pend_update_d;
            pend_show_q   <= pend_show_d;
            lat_opnd_q    <= lat_opnd_d;
            lat_op_q      <= lat_op_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            prod_q        <= prod_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign result     = result_q;
    assign disp_total = disp_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a vector table of store/update
// commands with expected accumulator/overflow/latency, a scoreboard of
// expected results popped on each done pulse, and hand-written sequences
// for simultaneous commands, clear during multiply and reset during exec.
module tb_calc_sequencer;

    logic       clk;
    logic       reset_n;
    logic       store_tgl;
    logic       update_tgl;
    logic       show_tgl;
    logic       clear_tgl;
    logic [7:0] operand;
    logic [1:0] op;
    logic [7:0] result;
    logic       disp_total;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_checks;
    int n_err;

    typedef struct packed {
        logic [7:0] res;
        logic       ovf_e;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        logic       is_store;
        logic [7:0] opnd;
        logic [1:0] opc;
        logic [7:0] exp_acc;
        logic       exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vec[14];

    calc_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .store_tgl (store_tgl),
        .update_tgl(update_tgl),
        .show_tgl  (show_tgl),
        .clear_tgl (clear_tgl),
        .operand   (operand),
        .op        (op),
        .result    (result),
        .disp_total(disp_total),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        sb_t e;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_result", {24'd0, result}, {24'd0, e.res});
                check("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf_e});
            end
        end
    end

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    // Issue one store/update, then measure done latency and busy length.
    // Latency counts negedges from the issue point: the detection edge is
    // followed by negedge 2, so LOAD/EXEC done lands on 4 and MUL on 11.
    task automatic run_cmd(input logic is_store, input logic [7:0] opnd_v,
                           input logic [1:0] op_v, input logic [7:0] exp_acc,
                           input logic exp_ovf, input int exp_lat);
        int lat;
        int nbusy;
        lat = 0;
        nbusy = 0;
        wait_pos();
        operand = opnd_v;
        op = op_v;
        if (is_store) store_tgl = ~store_tgl;
        else update_tgl = ~update_tgl;
        sb.push_back(sb_t'{exp_acc, exp_ovf});
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (c == 3) begin
                // After dispatch: the inputs must no longer matter.
                operand = 8'($urandom_range(0, 255));
                op = 2'($urandom_range(0, 3));
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", nbusy, exp_lat - 2);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic show_flip(input logic exp_disp, input logic [7:0] exp_res);
        wait_pos();
        show_tgl = ~show_tgl;
        wait_pos();
        wait_pos();
        check("show_disp", {31'd0, disp_total}, {31'd0, exp_disp});
        check("show_result", {24'd0, result}, {24'd0, exp_res});
    endtask

    // Count done pulses over ncyc negedges, recording the first two positions.
    task automatic count_done(input int ncyc, output int cnt, output int p1, output int p2);
        cnt = 0;
        p1 = 0;
        p2 = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (cnt == 1) p1 = c;
                if (cnt == 2) p2 = c;
            end
        end
    endtask

    initial begin
        int cnt;
        int p1;
        int p2;
        n_checks = 0;
        n_err = 0;
        reset_n = 1'b0;
        store_tgl = 1'b0;
        update_tgl = 1'b0;
        show_tgl = 1'b0;
        clear_tgl = 1'b0;
        operand = 8'd0;
        op = 2'd0;

        vec[0]  = '{1'b1, 8'd200, 2'b00, 8'd200, 1'b0, 4};
        vec[1]  = '{1'b0, 8'd100, 2'b00, 8'd44,  1'b1, 4};
        vec[2]  = '{1'b0, 8'd50,  2'b01, 8'd250, 1'b1, 4};
        vec[3]  = '{1'b0, 8'd7,   2'b11, 8'd7,   1'b0, 4};
        vec[4]  = '{1'b0, 8'd8,   2'b00, 8'd15,  1'b0, 4};
        vec[5]  = '{1'b1, 8'd12,  2'b10, 8'd12,  1'b0, 4};
        vec[6]  = '{1'b0, 8'd11,  2'b10, 8'd132, 1'b0, 11};
        vec[7]  = '{1'b1, 8'd20,  2'b01, 8'd20,  1'b0, 4};
        vec[8]  = '{1'b0, 8'd20,  2'b10, 8'd144, 1'b1, 11};
        vec[9]  = '{1'b0, 8'd44,  2'b01, 8'd100, 1'b0, 4};
        vec[10] = '{1'b0, 8'd0,   2'b10, 8'd0,   1'b0, 11};
        vec[11] = '{1'b1, 8'd255, 2'b00, 8'd255, 1'b0, 4};
        vec[12] = '{1'b0, 8'd255, 2'b10, 8'd1,   1'b1, 11};
        vec[13] = '{1'b0, 8'd255, 2'b00, 8'd0,   1'b1, 4};

        // Reset state.
        @(negedge clk);
        check("reset_outputs", {20'd0, result, disp_total, ovf, busy, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Store 25: result shows opnd_reg, then acc after show flip.
        run_cmd(1'b1, 8'd25, 2'b00, 8'd25, 1'b0, 4);
        show_flip(1'b1, 8'd25);

        // Table of commands with accumulator displayed.
        for (int i = 0; i < 14; i++) begin
            run_cmd(vec[i].is_store, vec[i].opnd, vec[i].opc,
                    vec[i].exp_acc, vec[i].exp_ovf, vec[i].exp_lat);
        end

        // Store and update in the same cycle: store first, then update.
        run_cmd(1'b1, 8'd3, 2'b00, 8'd3, 1'b0, 4);
        wait_pos();
        operand = 8'd5;
        op = 2'b00;
        store_tgl = ~store_tgl;
        update_tgl = ~update_tgl;
        sb.push_back(sb_t'{8'd5, 1'b0});
        sb.push_back(sb_t'{8'd10, 1'b0});
        count_done(14, cnt, p1, p2);
        check("simul_done_count", cnt, 2);
        check("simul_first_done", p1, 4);
        check("simul_second_done", p2, 7);

        // Clear during MUL cycle 4 aborts the multiply.
        run_cmd(1'b1, 8'd12, 2'b00, 8'd12, 1'b0, 4);
        wait_pos();
        operand = 8'd11;
        op = 2'b10;
        update_tgl = ~update_tgl;
        repeat (5) @(posedge clk);
        #1;
        check("mul_busy_before_clear", {31'd0, busy}, 32'd1);
        clear_tgl = ~clear_tgl;
        wait_pos();
        check("clear_busy", {31'd0, busy}, 32'd0);
        check("clear_outputs", {22'd0, result, disp_total, ovf}, 32'd0);
        count_done(12, cnt, p1, p2);
        check("clear_no_done", cnt, 0);

        // Reset asserted during EXEC.
        run_cmd(1'b1, 8'd10, 2'b00, 8'd10, 1'b0, 4);
        show_flip(1'b1, 8'd10);
        wait_pos();
        operand = 8'd1;
        op = 2'b00;
        update_tgl = ~update_tgl;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        store_tgl = 1'b0;
        update_tgl = 1'b0;
        show_tgl = 1'b0;
        clear_tgl = 1'b0;
        #1;
        check("async_reset_outputs", {20'd0, result, disp_total, ovf, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_done(4, cnt, p1, p2);
        check("post_reset_no_done", cnt, 0);
        check("post_reset_result", {24'd0, result}, 32'd0);

        // One flip of each command after reset gives exactly one event each.
        wait_pos();
        operand = 8'd9;
        op = 2'b00;
        store_tgl = ~store_tgl;
        update_tgl = ~update_tgl;
        show_tgl = ~show_tgl;
        sb.push_back(sb_t'{8'd9, 1'b0});
        sb.push_back(sb_t'{8'd9, 1'b0});
        count_done(14, cnt, p1, p2);
        check("post_reset_done_count", cnt, 2);
        check("post_reset_disp", {31'd0, disp_total}, 32'd1);
        check("post_reset_acc", {24'd0, result}, 32'd18);
        check("post_reset_ovf", {31'd0, ovf}, 32'd0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port store_tgl  input  1  toggle-encoded "store operand" command; each level change = one event.
REQ-004 SHALL have port update_tgl  input  1  toggle-encoded "apply op to accumulator" command.
REQ-005 SHALL have port show_tgl  input  1  toggle-encoded "flip display source" command.
REQ-006 SHALL have port clear_tgl  input  1  toggle-encoded "clear all" command.
REQ-007 SHALL have port operand  input  8  unsigned operand, sampled at command dispatch.
REQ-008 SHALL have port op  input  2  00 add, 01 sub, 10 mul, 11 pass; sampled at dispatch.
REQ-009 SHALL have port result  output  8  acc when disp_total=1, else opnd_reg.
REQ-010 SHALL have port disp_total  output  1  display-source flag.
REQ-011 SHALL have port ovf  output  1  sticky overflow of last update.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on store/update completion.

Function
REQ-014 SHALL detect an event on each *_tgl input when its registered previous value differs from its current value at a posedge.
REQ-015 SHALL set one pending flag per command type on event; repeat events of one type while pending SHALL merge into one.
REQ-016 SHALL act on clear in the detection cycle in any state: acc, opnd_reg, ovf, disp_total, and all pending flags to 0; state to IDLE; any MUL aborted; no done pulse.
REQ-017 SHALL, in IDLE, dispatch exactly one pending command per cycle, priority store > update > show, clearing its flag.
REQ-018 SHALL implement states IDLE, LOAD, EXEC, MUL, DONE; the only entry to LOAD is store dispatch; entry to EXEC is update with op!=10; entry to MUL is update with op=10.
REQ-019 SHALL, on show dispatch, invert disp_total in the dispatch cycle and remain in IDLE; no done pulse.
REQ-020 SHALL, in LOAD (1 cycle), write acc<=operand and opnd_reg<=operand, clear ovf, then enter DONE.
REQ-021 SHALL, in EXEC (1 cycle), write opnd_reg<=operand and acc<=low 8 bits of acc+operand, acc-operand, or operand (pass); ovf=carry-out (add), borrow (sub), 0 (pass); then DONE.
REQ-022 SHALL, in MUL, perform 8-cycle shift-add of acc x operand with a 16-bit product; acc<=product[7:0]; ovf=|product[15:8]; then DONE.
REQ-023 SHALL hold DONE one cycle with done=1, then return to IDLE.
REQ-024 SHALL latch operand/op at dispatch; changes to either during LOAD/EXEC/MUL SHALL have no effect.
REQ-025 SHALL latencies from detection edge k: dispatch at k+1; LOAD/EXEC result at k+2, done high in cycle after k+2; MUL result at k+9.
REQ-026 SHALL accept events arriving while busy into pending flags and serve them upon return to IDLE.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE, acc=0, opnd_reg=0, all pending flags 0, all toggle-history registers 0, and outputs result=0, disp_total=0, ovf=0, busy=0, done=0.
REQ-028 SHALL abort any in-flight operation on reset assertion without a done pulse.

Structure
REQ-029 SHALL place state encodings and op codes (OP_ADD, OP_SUB, OP_MUL, OP_PASS) in shared package calc_pkg.
REQ-030 SHALL implement toggle-to-event detection as sub-module tgl_edge, instantiated four times.
REQ-031 SHALL implement the shift-add multiplier inside calc_sequencer; no sub-module.

Verification
REQ-032 SHALL test: store_tgl flip with operand=25 -> done pulse at k+2, acc=25, result=25 after show flip.
REQ-033 SHALL test: acc=200, update op=00 operand=100 -> acc=44, ovf=1 at k+2.
REQ-034 SHALL test: acc=12, update op=10 operand=11 -> busy for 9 cycles, acc=132, ovf=0; acc=20 x 20 -> acc=144, ovf=1.
REQ-035 SHALL test: store and update toggled in the same cycle with operand=5, op=00, acc=3 -> store served first (acc=5), then update (acc=10), two done pulses.
REQ-036 SHALL test: clear_tgl flip during MUL cycle 4 -> next cycle IDLE, acc=0, busy=0, no done pulse.
REQ-037 SHALL test: reset_n low during EXEC -> all outputs 0 asynchronously; after release, first toggle change of each input is the only event detected.
